// File: rtl/multi_pulse_stretcher.sv
// multi_pulse_stretcher: per-channel trigger synchroniser, edge detector and
// retriggerable one-shot producing pulses of exactly stretch_len clk cycles.
module multi_pulse_stretcher #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i_trig,
    input  logic [CHANNELS-1:0] i_en,
    input  logic [CHANNELS-1:0] i_retrig_en,
    input  logic [CNT_W-1:0]    i_stretch_len,
    input  logic [CHANNELS-1:0] i_ovr_clr,
    output logic [CHANNELS-1:0] o_pulse_out,
    output logic [CHANNELS-1:0] o_done,
    output logic [CHANNELS-1:0] o_overrun
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] r_s_d;
    logic [CHANNELS-1:0] w_edge;
    logic                w_len_nz;

    assign w_len_nz = |i_stretch_len;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_s = i_trig;
    end else begin : g_sync
        logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            end else begin
                r_sync[0] <= i_trig;
                for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            end
        end
        assign w_s = r_sync[SYNC_STAGES-1];
    end

    // s_d resets low so a trigger held through reset release still yields one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_s_d <= '0;
        else     r_s_d <= w_s;
    end

    assign w_edge = w_s & ~r_s_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           r_state, w_state_nxt;
        logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic             r_done, w_done_nxt;
        logic             r_ovr, w_ovr_nxt;
        logic             w_accept;
        logic             w_drop;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_done  <= 1'b0;
                r_ovr   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_done  <= w_done_nxt;
                r_ovr   <= w_ovr_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_done_nxt  = 1'b0;
            w_accept    = w_edge[c] & i_en[c] & w_len_nz & ((r_state == IDLE) | i_retrig_en[c]);
            w_drop      = (r_state == ACTIVE) & w_edge[c] & i_en[c] & w_len_nz & ~i_retrig_en[c];
            if (r_state == IDLE) begin
                if (w_accept) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = i_stretch_len;
                end
            end else if (!i_en[c]) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else if (w_accept) begin
                w_cnt_nxt = i_stretch_len;
            end else if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_done_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            w_ovr_nxt = w_drop | (r_ovr & ~i_ovr_clr[c]);
        end

        assign o_pulse_out[c] = (r_state == ACTIVE);
        assign o_done[c]      = r_done;
        assign o_overrun[c]   = r_ovr;
    end
endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// tb_multi_pulse_stretcher: directed scenarios plus random traffic, checked every
// cycle against a deadline-based reference model of each channel.
module tb_multi_pulse_stretcher;
    localparam int CH = 4;
    localparam int CW = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] i_trig = '0;
    logic [CH-1:0] i_en = '1;
    logic [CH-1:0] i_retrig_en = '0;
    logic [CW-1:0] i_stretch_len = 16'd5;
    logic [CH-1:0] i_ovr_clr = '0;
    logic [CH-1:0] o_pulse_out;
    logic [CH-1:0] o_done;
    logic [CH-1:0] o_overrun;

    int n_chk = 0;
    int n_fail = 0;

    multi_pulse_stretcher #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .clk(clk),
        .rst(rst),
        .i_trig(i_trig),
        .i_en(i_en),
        .i_retrig_en(i_retrig_en),
        .i_stretch_len(i_stretch_len),
        .i_ovr_clr(i_ovr_clr),
        .o_pulse_out(o_pulse_out),
        .o_done(o_done),
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel is a deadline (absolute cycle at which the
    // pulse goes low); trig samples pass through a SS-deep delay history.
    int unsigned   n = 0;
    int unsigned   dl [CH];
    logic [CH-1:0] hist [SS+2];
    logic [CH-1:0] ovr_m, exp_pulse, exp_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) dl[c] = 0;
            for (int k = 0; k < SS + 2; k++) hist[k] = '0;
            ovr_m = '0;
            exp_pulse = '0;
            exp_done = '0;
        end else begin
            logic [CH-1:0] edg;
            n++;
            for (int k = SS + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = i_trig;
            edg = hist[SS] & ~hist[SS+1];
            for (int c = 0; c < CH; c++) begin
                bit act, lnz;
                act = (n <= dl[c]);
                lnz = (i_stretch_len != 0);
                exp_done[c] = 1'b0;
                if (act && !i_en[c]) dl[c] = n;
                else if (edg[c] && i_en[c] && lnz && (!act || i_retrig_en[c])) dl[c] = n + i_stretch_len;
                else if (act && n == dl[c]) exp_done[c] = 1'b1;
                if (act && i_en[c] && edg[c] && !i_retrig_en[c] && lnz) ovr_m[c] = 1'b1;
                else if (i_ovr_clr[c]) ovr_m[c] = 1'b0;
                exp_pulse[c] = (n < dl[c]);
            end
        end
    end

    int pw [CH];
    int dc [CH];
    initial for (int c = 0; c < CH; c++) begin pw[c] = 0; dc[c] = 0; end

    always @(negedge clk) begin
        if (!rst) begin
            check("pulse", o_pulse_out, exp_pulse);
            check("done", o_done, exp_done);
            check("overrun", o_overrun, ovr_m);
            for (int c = 0; c < CH; c++) begin
                pw[c] += int'(o_pulse_out[c]);
                dc[c] += int'(o_done[c]);
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_trig(input int c);
        i_trig[c] = 1'b1;
        cyc(1);
        i_trig[c] = 1'b0;
    endtask

    int bp, bd;

    initial begin
        cyc(3);
        check("rst_pulse", o_pulse_out, 0);
        check("rst_done", o_done, 0);
        check("rst_ovr", o_overrun, 0);
        rst = 1'b0;
        cyc(3);

        // one-shot, latency and width
        bp = pw[0]; bd = dc[0];
        i_trig[0] = 1'b1;
        cyc(1);
        i_trig[0] = 1'b0;
        check("lat_e1", o_pulse_out[0], 0);
        cyc(1);
        check("lat_e2", o_pulse_out[0], 0);
        cyc(1);
        check("lat_e3", o_pulse_out[0], 1);
        cyc(10);
        check("oneshot_width", pw[0] - bp, 5);
        check("oneshot_done", dc[0] - bd, 1);
        check("others_idle", pw[1] + pw[2] + pw[3], 0);

        // retrigger vs one-shot
        i_stretch_len = 16'd10;
        i_retrig_en[1] = 1'b1;
        bp = pw[1]; bd = dc[1];
        pulse_trig(1); cyc(3); pulse_trig(1); cyc(20);
        check("retrig_width", pw[1] - bp, 14);
        check("retrig_done", dc[1] - bd, 1);
        i_retrig_en[1] = 1'b0;
        bp = pw[1]; bd = dc[1];
        pulse_trig(1); cyc(3); pulse_trig(1); cyc(20);
        check("oneshot_drop_width", pw[1] - bp, 10);
        check("oneshot_drop_done", dc[1] - bd, 1);
        check("oneshot_drop_ovr", o_overrun[1], 1);

        // overrun set/clear race
        i_stretch_len = 16'd20;
        pulse_trig(2); cyc(5); pulse_trig(2); cyc(4);
        check("ovr_set", o_overrun[2], 1);
        i_trig[2] = 1'b1;
        cyc(1);
        i_trig[2] = 1'b0;
        cyc(1);
        i_ovr_clr[2] = 1'b1;
        cyc(1);
        i_ovr_clr[2] = 1'b0;
        check("ovr_race_set_wins", o_overrun[2], 1);
        i_ovr_clr[2] = 1'b1;
        cyc(1);
        i_ovr_clr[2] = 1'b0;
        check("ovr_clear", o_overrun[2], 0);
        cyc(25);

        // enable abort, zero length
        i_stretch_len = 16'd10;
        bd = dc[3];
        pulse_trig(3); cyc(6);
        check("abort_pre", o_pulse_out[3], 1);
        i_en[3] = 1'b0;
        cyc(1);
        check("abort_low", o_pulse_out[3], 0);
        i_en[3] = 1'b1;
        cyc(15);
        check("abort_no_done", dc[3] - bd, 0);
        i_stretch_len = 16'd0;
        bp = pw[3]; bd = dc[3];
        pulse_trig(3); cyc(10);
        check("zero_len_pulse", pw[3] - bp, 0);
        check("zero_len_done", dc[3] - bd, 0);
        check("zero_len_ovr", o_overrun[3], 0);

        // maximum length, mid-pulse length change ignored
        i_stretch_len = 16'hFFFF;
        bp = pw[0]; bd = dc[0];
        pulse_trig(0); cyc(10);
        i_stretch_len = 16'd3;
        cyc(65540);
        check("max_width", pw[0] - bp, 65535);
        check("max_done", dc[0] - bd, 1);

        // asynchronous reset mid-pulse, then trig held through release
        i_stretch_len = 16'd50;
        pulse_trig(0); cyc(10);
        check("rst_pre", o_pulse_out[0], 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pulse", o_pulse_out, 0);
        check("async_rst_done", o_done, 0);
        check("async_rst_ovr", o_overrun, 0);
        i_trig[1] = 1'b1;
        i_stretch_len = 16'd7;
        cyc(3);
        bp = pw[1]; bd = dc[1];
        rst = 1'b0;
        cyc(20);
        check("held_trig_width", pw[1] - bp, 7);
        check("held_trig_done", dc[1] - bd, 1);
        i_trig[1] = 1'b0;
        cyc(5);

        // concurrent start, then random traffic under the model
        i_stretch_len = 16'd6;
        i_retrig_en = 4'b0101;
        i_trig = 4'hF;
        cyc(1);
        i_trig = 4'h0;
        cyc(2); pulse_trig(0); pulse_trig(1); cyc(1); pulse_trig(2); pulse_trig(3);
        cyc(15);
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 4) == 0) i_trig[c] = ~i_trig[c];
                if ($urandom_range(0, 39) == 0) i_en[c] = ~i_en[c];
                if ($urandom_range(0, 29) == 0) i_retrig_en[c] = ~i_retrig_en[c];
                i_ovr_clr[c] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 49) == 0) i_stretch_len = CW'($urandom_range(0, 12));
            cyc(1);
        end
        i_trig = '0;
        i_ovr_clr = '0;
        cyc(20);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/multi_pulse_stretcher.md
Name: multi_pulse_stretcher

Overview:
- Parametrised, multi-channel pulse stretcher.
- Each channel turns a short or asynchronous trigger into an output pulse of exactly stretch_len clk cycles.
- Per-channel features: input synchroniser, rising-edge detect, retrigger mode, enable, end-of-pulse strobe, sticky overrun flag.
- Sits between raw inputs (buttons, sensor strobes, cross-domain pulses) and slow consumers (LEDs, 7-seg, game FSMs).

Parameters:
- CHANNELS, 4, number of independent channels.
- CNT_W, 16, length counter width; max pulse is 2^CNT_W-1 cycles.
- SYNC_STAGES, 2, synchroniser flops per trigger input. 0 means trig is already synchronous to clk.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- trig  in  CHANNELS  raw trigger per channel; rising edge starts a pulse.
- en  in  CHANNELS  channel enable; low forces the channel idle.
- retrig_en  in  CHANNELS  1 = retriggerable, 0 = one-shot.
- stretch_len  in  CNT_W  pulse length in cycles, shared by all channels, sampled at load.
- ovr_clr  in  CHANNELS  one-cycle clear of the overrun flags.
- pulse_out  out  CHANNELS  stretched pulse, registered.
- done  out  CHANNELS  one-cycle strobe at pulse end, registered.
- overrun  out  CHANNELS  sticky: a trigger edge was dropped.

Behaviour:
- Reset (async, immediate):
  - All sync flops, edge-history flops, counters, pulse_out, done and overrun go to 0.
  - Each channel enters IDLE.
- Synchroniser and edge detect, per channel:
  - s = output of the last sync flop (s = trig when SYNC_STAGES = 0).
  - s_d = s delayed one cycle.
  - edge = s & ~s_d.
  - trig held high across reset release counts as one edge.
- States per channel: IDLE (pulse_out=0) and ACTIVE (pulse_out=1). The counter cnt holds the remaining cycles.
- IDLE:
  - If edge & en & stretch_len != 0: cnt <= stretch_len, go to ACTIVE.
  - Otherwise stay in IDLE.
  - An edge with stretch_len == 0 is ignored: no pulse, no done, no overrun.
- ACTIVE, each cycle:
  - If en == 0: go to IDLE next cycle, cnt <= 0, no done.
  - Else if edge & retrig_en & stretch_len != 0: cnt <= stretch_len (reload), stay ACTIVE.
  - Else if cnt == 1: go to IDLE, cnt <= 0, done <= 1 for one cycle, coincident with pulse_out's first low cycle.
  - Else: cnt <= cnt - 1.
  - If edge & ~retrig_en (including the cnt == 1 cycle): the edge is dropped and overrun <= 1.
- Latency:
  - pulse_out rises SYNC_STAGES+1 clk edges after the first edge that samples trig high.
  - The pulse lasts exactly stretch_len cycles when not retriggered.
  - A retriggered pulse stays high until stretch_len cycles after the last accepted edge.
  - An edge on the final cycle in retrig mode extends the pulse with no gap and no done.
- stretch_len changes while ACTIVE do not affect the running count; the new value is used only at the next load or reload.
- overrun:
  - Cleared by ovr_clr.
  - A set and a clear in the same cycle: set wins.
  - Edges arriving while en = 0 do not set overrun.
- Channels are fully independent; no shared state except stretch_len.
- Counter arithmetic is unsigned CNT_W bits. cnt never wraps, since decrement happens only when cnt >= 2.

Test Plan:
- Basic one-shot: CHANNELS=4, SYNC_STAGES=2, stretch_len=5; a 1-cycle trig[0] pulse -> pulse_out[0] high for exactly 5 cycles, starting 3 edges after trig is sampled; done[0] for 1 cycle right after; other channels stay 0.
- Retrigger: retrig_en[1]=1, stretch_len=10; trig[1] edges 4 cycles apart, then silence -> pulse_out[1] = 14 cycles total, a single done; the same sequence with retrig_en[1]=0 -> a 10-cycle pulse, overrun[1]=1.
- Overrun clear race: overrun[2] set; assert ovr_clr[2] in the same cycle as a new dropped edge -> overrun[2] stays 1; next ovr_clr[2] alone -> 0.
- Enable abort and zero length: deassert en[3] mid-pulse -> pulse_out[3] low next cycle, no done; edge with stretch_len=0 -> no pulse, no done.
- Boundary and reset: stretch_len=16'hFFFF -> 65535-cycle pulse; change stretch_len to 3 mid-pulse -> no effect; assert rst mid-pulse -> all outputs 0 immediately; trig held high through rst release -> exactly one pulse.
- Concurrency: all 4 channels triggered on the same cycle with mixed retrig_en and staggered edges -> each channel matches an independent reference model cycle-for-cycle.
